obi_bridge_arbiter: RTL



---
 rtl/obi_id_fifo.sv | 66 ++++++
 rtl/obi_bridge_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/obi_id_fifo.sv
// rtl/obi_id_fifo.sv - in-order queue of requester IDs for outstanding OBI transactions
module obi_id_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
        end
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries are only meaningful below count_q, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/obi_bridge_arbiter.sv
// rtl/obi_bridge_arbiter.sv - round-robin arbiter sharing one OBI bridge port with in-order response routing
module obi_bridge_arbiter #(
    parameter  int NUM_REQ         = 4,
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int IDX_W           = $clog2(NUM_REQ),
    localparam int BE_W            = DATA_WIDTH / 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*BE_W-1:0]       be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          obi_req_o,
    output logic                          obi_we_o,
    output logic [ADDR_WIDTH-1:0]         obi_addr_o,
    output logic [BE_W-1:0]               obi_be_o,
    output logic [DATA_WIDTH-1:0]         obi_wdata_o,
    input  logic                          obi_gnt_i,
    input  logic                          obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         obi_rdata_i,
    output logic [CNT_W-1:0]              outstanding_o,
    output logic                          err_unexp_rsp_o
);

    typedef enum logic {ST_ARB, ST_LOCK} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] win_idx, cand, sel_idx, head_idx;
    logic             win_found, sel_valid, grant, pop, fifo_full, fifo_empty;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Scan from the highest offset down so the last hit is the one nearest rr_ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_idx     = (state_q == ST_LOCK) ? lock_idx_q : win_idx;
        sel_valid   = (state_q == ST_LOCK) ? req_i[lock_idx_q] : win_found;
        obi_req_o   = sel_valid && !fifo_full;
        obi_we_o    = we_i[sel_idx];
        obi_addr_o  = addr_i[int'(sel_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        obi_be_o    = be_i[int'(sel_idx) * BE_W +: BE_W];
        obi_wdata_o = wdata_i[int'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];
        grant       = obi_req_o && obi_gnt_i;
        gnt_o       = '0;
        if (grant) begin
            gnt_o[sel_idx] = 1'b1;
        end
        pop      = obi_rvalid_i && !fifo_empty;
        rvalid_o = '0;
        if (pop) begin
            rvalid_o[head_idx] = 1'b1;
        end
        rdata_o = obi_rdata_i;
        err_d   = err_q || (obi_rvalid_i && fifo_empty);
    end

    // A full FIFO freezes the FSM; a pop this cycle only frees a slot for the next.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (!fifo_full) begin
            if (state_q == ST_ARB) begin
                if (win_found && obi_gnt_i) begin
                    rr_ptr_d = idx_inc(win_idx);
                end else if (win_found) begin
                    lock_idx_d = win_idx;
                    state_d    = ST_LOCK;
                end
            end else begin
                if (!req_i[lock_idx_q]) begin
                    state_d = ST_ARB;
                end else if (obi_gnt_i) begin
                    rr_ptr_d = idx_inc(lock_idx_q);
                    state_d  = ST_ARB;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    assign err_unexp_rsp_o = err_q;

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (grant),
        .push_data_i (sel_idx),
        .pop_i       (pop),
        .head_o      (head_idx),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding_o)
    );

endmodule
